// File: rtl/reg_ram_pkg.sv
// Shared types and defaults for the parametrised register-file RAM.
// Optional build macro: REG_RAM_WRITE_FIRST_EN (see param_reg_ram).
package reg_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

    localparam int DATA_W_DEF = 4;
    localparam int ADDR_W_DEF = 2;

endpackage

// File: rtl/reg_ram_clear_seq.sv
// Clear sequencer: walks every entry after reset or on request,
// issuing one CLEAR_VAL write strobe per cycle while busy.
import reg_ram_pkg::*;

module reg_ram_clear_seq #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    output logic              busy_o,
    output logic              clr_we_o,
    output logic [ADDR_W-1:0] clr_addr_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST = '1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_o  = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                // terminal compare keeps the walk from leaving early
                if (idx_q == LAST) begin
                    done_o  = 1'b1;
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            end
            ST_IDLE: begin
                if (clr_i) begin
                    state_d = ST_CLEAR;
                    idx_d   = '0;
                end
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    assign busy_o     = (state_q == ST_CLEAR);
    assign clr_we_o   = busy_o && rst_n_i;
    assign clr_addr_o = idx_q;

endmodule

// File: rtl/param_reg_ram.sv
// DATA_W x 2**ADDR_W register RAM with registered read and clear sequencer.
// Define REG_RAM_WRITE_FIRST_EN for write-first same-address bypass.
import reg_ram_pkg::*;

module param_reg_ram #(
    parameter int              DATA_W    = DATA_W_DEF,
    parameter int              ADDR_W    = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              clr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              clk_out
);

    localparam int              DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST  = '1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d;
    logic              seq_we, seq_done;
    logic [ADDR_W-1:0] seq_addr;
    logic              user_we, rd_en, bypass;

    reg_ram_clear_seq #(
        .ADDR_W (ADDR_W)
    ) u_clear_seq (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .clr_i      (clr),
        .busy_o     (busy),
        .clr_we_o   (seq_we),
        .clr_addr_o (seq_addr),
        .done_o     (seq_done)
    );

    // a clear request drops a same-cycle user write
    assign user_we = rst_n && !busy && we && !clr;
    assign rd_en   = !busy && re;

`ifdef REG_RAM_WRITE_FIRST_EN
    assign bypass = user_we && (waddr == raddr);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rd_en;
        if (rd_en) begin
            rdata_d = bypass ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (seq_we) begin
            mem_q[seq_addr] <= CLEAR_VAL;
        end else if (user_we) begin
            mem_q[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && seq_done) begin
            assert (seq_we && seq_addr == LAST);
        end
    end

    assign rdata   = rdata_q;
    assign rvalid  = rvalid_q;
    assign clk_out = clk;

endmodule

// File: tb/tb_param_reg_ram.sv
// Directed bench for param_reg_ram: default build plus a CLEAR_VAL=0x9 copy.
module tb_param_reg_ram;

    logic       clk = 1'b0;
    logic       rst_n, we, re, clr;
    logic [1:0] waddr, raddr;
    logic [3:0] wdata;
    logic [3:0] rdata, rdata9;
    logic       rvalid, rvalid9, busy, busy9, clk_out, clk_out9;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_reg_ram u_dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
        .wdata(wdata), .re(re), .raddr(raddr), .clr(clr),
        .rdata(rdata), .rvalid(rvalid), .busy(busy),
        .clk_out(clk_out)
    );

    param_reg_ram #(.CLEAR_VAL(4'h9)) u_dut9 (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr),
        .wdata(wdata), .re(re), .raddr(raddr), .clr(clr),
        .rdata(rdata9), .rvalid(rvalid9), .busy(busy9),
        .clk_out(clk_out9)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        int n;
        rst_n = 1'b0; we = 0; re = 0; clr = 0;
        waddr = 0; raddr = 0; wdata = 0;
        tick(); tick();
        checks++;
        if (rdata !== 4'h0 || rvalid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL reset got rd=%h rv=%b busy=%b exp 0/0/1",
                     rdata, rvalid, busy);
        end
        checks++;
        if (clk_out !== clk) begin
            failures++;
            $display("FAIL clk_out got=%b exp=%b", clk_out, clk);
        end
        rst_n = 1'b1;
        count_busy(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL reset_busy_len got=%0d exp=4", n);
        end
        for (int i = 0; i < 4; i++) begin
            re = 1; raddr = 2'(i);
            tick();
            re = 0;
            checks++;
            if (rvalid !== 1'b1 || rdata !== 4'h0 || rdata9 !== 4'h9) begin
                failures++;
                $display("FAIL init_rd%0d got rv=%b rd=%h rd9=%h exp 1/0/9",
                         i, rvalid, rdata, rdata9);
            end
            tick();
            checks++;
            if (rvalid !== 1'b0) begin
                failures++;
                $display("FAIL rvalid_pulse%0d got=%b exp=0", i, rvalid);
            end
        end
    endtask

    task automatic test_write_read();
        logic [3:0] wv [4] = '{4'hA, 4'h5, 4'hC, 4'h3};
        for (int i = 0; i < 4; i++) begin
            we = 1; waddr = 2'(i); wdata = wv[i];
            tick();
        end
        we = 0;
        checks++;
        if (rvalid !== 1'b0) begin
            failures++;
            $display("FAIL wr_no_rvalid got=%b exp=0", rvalid);
        end
        for (int i = 3; i >= 0; i--) begin
            re = 1; raddr = 2'(i);
            tick();
            checks++;
            if (rvalid !== 1'b1 || rdata !== wv[i]) begin
                failures++;
                $display("FAIL b2b_rd%0d got rv=%b rd=%h exp 1/%h",
                         i, rvalid, rdata, wv[i]);
            end
        end
        re = 0;
    endtask

    task automatic test_rdw();
        logic [3:0] exp_first;
`ifdef REG_RAM_WRITE_FIRST_EN
        exp_first = 4'h7;
`else
        exp_first = 4'hC;
`endif
        we = 1; waddr = 2; wdata = 4'h7;
        re = 1; raddr = 2;
        tick();
        we = 0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== exp_first) begin
            failures++;
            $display("FAIL rdw got rv=%b rd=%h exp 1/%h",
                     rvalid, rdata, exp_first);
        end
        tick();
        re = 0;
        checks++;
        if (rdata !== 4'h7) begin
            failures++;
            $display("FAIL rdw_after got=%h exp=7", rdata);
        end
    endtask

    task automatic test_busy_ignore();
        int n;
        clr = 1;
        tick();
        clr = 0;
        we = 1; waddr = 1; wdata = 4'hF;
        re = 1; raddr = 1;
        tick();
        we = 0; re = 0;
        checks++;
        if (rvalid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_ignore got rv=%b busy=%b exp 0/1",
                     rvalid, busy);
        end
        count_busy(n);
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL busy_rest got=%0d exp=3", n);
        end
        re = 1; raddr = 1;
        tick();
        re = 0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 4'h0 || rdata9 !== 4'h9) begin
            failures++;
            $display("FAIL busy_rd1 got rv=%b rd=%h rd9=%h exp 1/0/9",
                     rvalid, rdata, rdata9);
        end
    endtask

    task automatic test_clr_collision();
        int n;
        we = 1; waddr = 1; wdata = 4'h5;
        tick();
        clr = 1; we = 1; waddr = 1; wdata = 4'hF;
        re = 1; raddr = 1;
        tick();
        clr = 0; we = 0; re = 0;
        checks++;
        if (rvalid !== 1'b1 || rdata !== 4'h5 || rdata9 !== 4'h5) begin
            failures++;
            $display("FAIL clr_rd got rv=%b rd=%h rd9=%h exp 1/5/5",
                     rvalid, rdata, rdata9);
        end
        count_busy(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL clr_busy_len got=%0d exp=4", n);
        end
        for (int i = 0; i < 4; i++) begin
            re = 1; raddr = 2'(i);
            tick();
            checks++;
            if (rvalid !== 1'b1 || rdata !== 4'h0 || rdata9 !== 4'h9) begin
                failures++;
                $display("FAIL clr_rd%0d got rv=%b rd=%h rd9=%h exp 1/0/9",
                         i, rvalid, rdata, rdata9);
            end
        end
        re = 0;
    endtask

    task automatic test_reset_midclear();
        int n;
        we = 1; waddr = 0; wdata = 4'hA;
        tick();
        we = 0; re = 1; raddr = 0;
        tick();
        checks++;
        if (rvalid !== 1'b1 || rdata !== 4'hA) begin
            failures++;
            $display("FAIL pre_rst_rd got rv=%b rd=%h exp 1/a",
                     rvalid, rdata);
        end
        re = 0; clr = 1;
        tick();
        clr = 0;
        tick();
        rst_n = 0; re = 1; raddr = 0;
        tick();
        re = 0;
        checks++;
        if (rdata !== 4'h0 || rvalid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_rst got rd=%h rv=%b busy=%b exp 0/0/1",
                     rdata, rvalid, busy);
        end
        rst_n = 1;
        count_busy(n);
        checks++;
        if (n != 4) begin
            failures++;
            $display("FAIL mid_rst_busy_len got=%0d exp=4", n);
        end
        for (int i = 0; i < 4; i++) begin
            re = 1; raddr = 2'(i);
            tick();
            checks++;
            if (rvalid !== 1'b1 || rdata !== 4'h0 || rdata9 !== 4'h9) begin
                failures++;
                $display("FAIL mid_rst_rd%0d got rv=%b rd=%h rd9=%h exp 1/0/9",
                         i, rvalid, rdata, rdata9);
            end
        end
        re = 0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rdw();
        test_busy_ignore();
        test_clr_collision();
        test_reset_midclear();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
